// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, encodings and the
// program-loader state enumeration.
package cpu_pkg;

   localparam int INSTR_W    = 59;

   localparam int FLAG_LSB   = 57;
   localparam int FLAG_W     = 2;
   localparam int OPCODE_LSB = 52;
   localparam int OPCODE_W   = 5;
   localparam int RD_LSB     = 47;
   localparam int RD_W       = 5;
   localparam int RS1_LSB    = 42;
   localparam int RS1_W      = 5;
   localparam int RS2_LSB    = 37;
   localparam int RS2_W      = 5;
   localparam int PC_LSB     = 32;
   localparam int PC_W       = 5;
   localparam int IMM_LSB    = 0;
   localparam int IMM_W      = 32;

   localparam logic [FLAG_W-1:0]   FLAG_REG = 2'b00;
   localparam logic [FLAG_W-1:0]   FLAG_IMM = 2'b01;
   localparam logic [OPCODE_W-1:0] OP_ADD   = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_MUL   = 5'b00001;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      HOLD,
      DONE,
      ERR
   } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word shift register. word/word_valid already include
// the byte being accepted this cycle, so the caller can register them directly.
module byte_assembler #(
   parameter int BYTES = 8,
   parameter int OUT_W = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data,
   input  logic             en,
   output logic [OUT_W-1:0] word,
   output logic             word_valid
);

   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [8*BYTES-9:0] sreg;
   logic [8*BYTES-1:0] full;
   logic [CW-1:0]      cnt;

   // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
   assign full       = {data, sreg};
   assign word       = full[OUT_W-1:0];
   assign word_valid = en && (cnt == CW'(BYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (en) begin
         sreg <= full[8*BYTES-1:8];
         cnt  <= word_valid ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes instructions into Imem while
// holding the CPU in reset, then releases it to start at Imem[0].
module imem_loader #(
   parameter int IMEM_DEPTH      = 32,
   parameter int ADDR_W          = 5,
   parameter int INSTR_W         = 59,
   parameter int BYTES_PER_INSTR = 8,
   parameter int RST_HOLD        = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         s_data,
   input  logic               s_valid,
   output logic               s_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_rst,
   output logic               done,
   output logic               err,
   output logic               pc_mismatch
);

   import cpu_pkg::*;

   localparam int HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   loader_state_t      state;
   logic [ADDR_W:0]    n;
   logic [ADDR_W-1:0]  idx;
   logic [HC_W-1:0]    hold_cnt;
   logic [INSTR_W-1:0] word;
   logic               word_valid;
   logic               accept;
   logic               last;

   assign accept = s_valid && s_ready;
   assign last   = ((ADDR_W+1)'(idx) + 1'b1) == n;

   byte_assembler #(
      .BYTES (BYTES_PER_INSTR),
      .OUT_W (INSTR_W)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .data       (s_data),
      .en         (accept && (state == LOAD)),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         s_ready     <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         cpu_rst     <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         pc_mismatch <= 1'b0;
         n           <= '0;
         idx         <= '0;
         hold_cnt    <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE: begin
               s_ready <= 1'b1;
               if (accept) begin
                  if (s_data == 8'd0 || int'(s_data) > IMEM_DEPTH) begin
                     state   <= ERR;
                     s_ready <= 1'b0;
                     err     <= 1'b1;
                  end else begin
                     n     <= s_data[ADDR_W:0];
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               // Write strobe is issued from the final-byte edge so it lands
               // in the cycle right after that byte is taken.
               if (word_valid) begin
                  state      <= WRITE;
                  s_ready    <= 1'b0;
                  imem_we    <= 1'b1;
                  imem_addr  <= idx;
                  imem_wdata <= word;
                  if (word[PC_LSB +: PC_W] != PC_W'(idx))
                     pc_mismatch <= 1'b1;
               end
            end
            WRITE: begin
               if (last) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end else begin
                  idx     <= idx + 1'b1;
                  state   <= LOAD;
                  s_ready <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt == HC_W'(RST_HOLD - 1)) begin
                  state   <= DONE;
                  cpu_rst <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            DONE, ERR: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
